// File: rtl/line_buffer_ctrl_if.sv
// Raster pixel stream into the line buffer controller.
// The source drives valid/data/last and the controller answers with ready.
interface line_buffer_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             s_ready;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Round-robin line buffer sequencer for a KERNEL-tall FIR window.
// Optional LB_OVF_CHK_EN: flag and drop pixels of overlong lines.
module line_buffer_ctrl #(
    parameter int WIDTH  = 8,
    parameter int LINE_W = 1920,
    parameter int LINES  = 1080,
    parameter int KERNEL = 3,
    parameter int ADDR_W = 11,
    localparam int BW    = (KERNEL > 1) ? $clog2(KERNEL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    line_buffer_ctrl_if.slave s,
    output logic [KERNEL-1:0] bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WIDTH-1:0]  bram_din,
    output logic [BW-1:0]     bank_base,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_col,
    output logic              frame_done,
    output logic              err
);
    localparam int LW = $clog2(LINES + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] col;
    logic [BW-1:0]     wr_bank;
    logic [BW-1:0]     wr_bank_inc;
    logic [LW-1:0]     line_cnt;
    logic [LW-1:0]     lc_nxt;
    logic              accept;
    logic              line_end;
    logic              frame_end;
    logic              col_end;
    logic              drop;
    logic              wr_en;
    logic              win_fire;

    assign s.s_ready   = ~rst & (state != DONE);
    assign accept      = s.s_valid & s.s_ready;
    assign line_end    = accept & s.s_last;
    assign lc_nxt      = line_cnt + LW'(line_end);
    assign frame_end   = line_end & (line_cnt == LW'(LINES - 1));
    assign col_end     = (col == ADDR_W'(LINE_W - 1));
    assign wr_bank_inc = (wr_bank == BW'(KERNEL - 1)) ? '0 : wr_bank + 1'b1;
    assign wr_en       = accept & ~drop;
    assign win_fire    = wr_en & (state == RUN);

    assign bram_we     = wr_en ? (KERNEL'(1) << wr_bank) : '0;
    assign bram_addr   = col;
    assign bram_din    = s.s_data;
    assign frame_done  = (state == DONE);

`ifdef LB_OVF_CHK_EN
    logic ovf;
    logic ovf_hit;
    logic err_q;

    // Past the last column without s_last the rest of the line is discarded.
    assign ovf_hit = accept & ~s.s_last & col_end;
    assign drop    = ovf;
    assign err     = err_q;

    // Sticky error plus per-line drop flag cleared when the line closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | ovf_hit;
            if (line_end) ovf <= 1'b0;
            else          ovf <= ovf | ovf_hit;
        end
    end
`else
    assign drop = 1'b0;
    assign err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: line count decides fill vs run, last line ends the frame.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, FILL, RUN: begin
                if (accept) begin
                    if (frame_end)                     state_nxt = DONE;
                    else if (int'(lc_nxt) >= KERNEL-1) state_nxt = RUN;
                    else                               state_nxt = FILL;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Column, bank rotation and line counting; frame end rewinds to bank 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            wr_bank  <= '0;
            line_cnt <= '0;
        end else if (line_end) begin
            col      <= '0;
            wr_bank  <= frame_end ? '0 : wr_bank_inc;
            line_cnt <= frame_end ? '0 : lc_nxt;
        end else if (accept) begin
`ifdef LB_OVF_CHK_EN
            col <= col_end ? col : col + 1'b1;
`else
            col <= col_end ? '0 : col + 1'b1;
`endif
        end
    end

    // Window tags follow the 1-cycle BRAM read of the accepted column.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            bank_base <= '0;
        end else begin
            win_valid <= win_fire;
            if (win_fire) begin
                win_col   <= col;
                bank_base <= wr_bank_inc;
            end
        end
    end
endmodule
